// File: rtl/sysbus_mem_responder.sv
// System-bus memory responder: 64-byte line reads and writes
// against a zero-initialised 64-bit word store.
module sysbus_mem_responder #(
    parameter int MEM_WORDS = 512,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqcyc,
    input  logic [63:0] req,
    input  logic [12:0] reqtag,
    output logic        reqack,
    output logic        respcyc,
    output logic [63:0] resp,
    output logic [12:0] resptag,
    input  logic        respack
);

    localparam int         AW       = $clog2(MEM_WORDS);
    localparam logic [3:0] TYPE_MEM = 4'h1;
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_DATA
    } state_t;

    state_t        state;
    logic [AW-1:0] base_word;
    logic          is_mem;
    logic [2:0]    beat;
    logic [3:0]    lat_cnt;

    logic [63:0] mem [MEM_WORDS] = '{default: 64'h0};

    logic [AW-1:0] line_word;
    logic [AW-1:0] cur_idx;
    logic [AW-1:0] nxt_idx;
    logic          wr_en;

    // Line base drops byte offset and word-in-line bits; upper bits wrap.
    assign line_word = {req[AW+2:6], 3'b000};
    assign cur_idx   = base_word | AW'(beat);
    assign nxt_idx   = base_word | AW'(beat + 3'd1);
    assign wr_en     = reset && (state == WR_DATA) && reqcyc && is_mem;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cur_idx] <= req;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            reqack    <= 1'b0;
            respcyc   <= 1'b0;
            resp      <= '0;
            resptag   <= '0;
            beat      <= '0;
            lat_cnt   <= '0;
            base_word <= '0;
            is_mem    <= 1'b0;
        end else begin
            reqack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (reqcyc) begin
                        base_word <= line_word;
                        resptag   <= reqtag;
                        is_mem    <= (reqtag[11:8] == TYPE_MEM);
                        reqack    <= 1'b1;
                        beat      <= '0;
                        lat_cnt   <= '0;
                        state     <= reqtag[12] ? RD_WAIT : WR_DATA;
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        state   <= RD_BURST;
                        respcyc <= 1'b1;
                        resp    <= is_mem ? mem[base_word] : '0;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                RD_BURST: begin
                    if (respack) begin
                        if (beat == 3'd7) begin
                            respcyc <= 1'b0;
                            beat    <= '0;
                            state   <= IDLE;
                        end else begin
                            beat <= beat + 3'd1;
                            resp <= is_mem ? mem[nxt_idx] : '0;
                        end
                    end
                end
                WR_DATA: begin
                    if (reqcyc) begin
                        reqack <= 1'b1;
                        if (beat == 3'd7) begin
                            beat  <= '0;
                            state <= IDLE;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: line writes, reads,
// backpressure, wrap, non-memory types and mid-burst reset.
module tb_sysbus_mem_responder;

    logic        clk;
    logic        reset;
    logic        reqcyc;
    logic [63:0] req;
    logic [12:0] reqtag;
    logic        reqack;
    logic        respcyc;
    logic [63:0] resp;
    logic [12:0] resptag;
    logic        respack;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] wdat [8];
    logic [63:0] rexp [8];

    sysbus_mem_responder #(
        .MEM_WORDS(512),
        .LATENCY  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .reqcyc (reqcyc),
        .req    (req),
        .reqtag (reqtag),
        .reqack (reqack),
        .respcyc(respcyc),
        .resp   (resp),
        .resptag(resptag),
        .respack(respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr_line(input logic [63:0] addr, input logic [12:0] tag,
                           input int stall_at, input int abort_at);
        reqcyc = 1'b1;
        req    = addr;
        reqtag = tag;
        @(negedge clk);
        check("wr_req_ack", 64'(reqack), 64'd1);
        for (int k = 0; k < 8; k++) begin
            if (k == abort_at) begin
                reqcyc = 1'b0;
                reset  = 1'b0;
                @(negedge clk);
                check("wr_abort_ack", 64'(reqack), 64'd0);
                reset = 1'b1;
                return;
            end
            if (k == stall_at) begin
                reqcyc = 1'b0;
                @(negedge clk);
                check("wr_stall_noack", 64'(reqack), 64'd0);
            end
            reqcyc = 1'b1;
            req    = wdat[k];
            @(negedge clk);
            check("wr_beat_ack", 64'(reqack), 64'd1);
            check("wr_no_resp", 64'(respcyc), 64'd0);
        end
        reqcyc = 1'b0;
        @(negedge clk);
        check("wr_done_noack", 64'(reqack), 64'd0);
    endtask

    task automatic rd_line(input logic [63:0] addr, input logic [12:0] tag,
                           input int bp_beat, input int bp_len,
                           input int abort_beat, input bit intrude);
        int n;
        respack = 1'b1;
        reqcyc  = 1'b1;
        req     = addr;
        reqtag  = tag;
        @(negedge clk);
        check("rd_req_ack", 64'(reqack), 64'd1);
        check("rd_req_noresp", 64'(respcyc), 64'd0);
        if (intrude) begin
            req    = 64'h0000_0000_0000_2000;
            reqtag = 13'h0100;
        end else begin
            reqcyc = 1'b0;
        end
        n = 0;
        while (!respcyc && n < 40) begin
            @(negedge clk);
            n++;
            check("rd_wait_noack", 64'(reqack), 64'd0);
        end
        check("rd_latency", 64'(n), 64'd4);
        if (!respcyc) begin
            reqcyc = 1'b0;
            return;
        end
        for (int k = 0; k < 8; k++) begin
            check("rd_data", resp, rexp[k]);
            check("rd_tag", 64'(resptag), 64'(tag));
            check("rd_noack", 64'(reqack), 64'd0);
            if (k == abort_beat) begin
                reset  = 1'b0;
                reqcyc = 1'b0;
                @(negedge clk);
                check("abort_valid", 64'(respcyc), 64'd0);
                check("abort_resp", resp, 64'd0);
                check("abort_tag", 64'(resptag), 64'd0);
                reset = 1'b1;
                return;
            end
            if (k == bp_beat) begin
                respack = 1'b0;
                repeat (bp_len) begin
                    @(negedge clk);
                    check("bp_valid", 64'(respcyc), 64'd1);
                    check("bp_resp", resp, rexp[k]);
                    check("bp_tag", 64'(resptag), 64'(tag));
                end
                respack = 1'b1;
            end
            @(negedge clk);
            if (k < 7) check("rd_valid", 64'(respcyc), 64'd1);
        end
        check("rd_end", 64'(respcyc), 64'd0);
        check("rd_end_noack", 64'(reqack), 64'd0);
        reqcyc = 1'b0;
        @(negedge clk);
        check("rd_idle", 64'(respcyc), 64'd0);
        check("rd_idle_noack", 64'(reqack), 64'd0);
    endtask

    initial begin
        reset   = 1'b0;
        reqcyc  = 1'b0;
        req     = '0;
        reqtag  = '0;
        respack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_reqack", 64'(reqack), 64'd0);
        check("rst_respcyc", 64'(respcyc), 64'd0);
        check("rst_resp", resp, 64'd0);
        check("rst_resptag", 64'(resptag), 64'd0);
        reset = 1'b1;

        // Request in the very first cycle out of reset, with a stall on beat 3.
        for (int k = 0; k < 8; k++) wdat[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        wr_line(64'h1000, 13'h0100, 3, -1);

        for (int k = 0; k < 8; k++) rexp[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        rd_line(64'h1000, 13'h1105, 2, 3, -1, 1'b0);
        rd_line(64'h1013, 13'h1106, -1, 0, -1, 1'b0);

        // Word 0 aliases 0x1000 in a 512-word store.
        for (int k = 0; k < 8; k++) wdat[k] = 64'hD000_0000_0000_0000 | 64'(k);
        wr_line(64'h0, 13'h0101, -1, -1);
        for (int k = 0; k < 8; k++) rexp[k] = 64'hD000_0000_0000_0000 | 64'(k);
        rd_line(64'h1000, 13'h1107, -1, 0, -1, 1'b0);

        for (int k = 0; k < 8; k++) rexp[k] = 64'h0;
        rd_line(64'h0, 13'h1208, -1, 0, -1, 1'b1);

        for (int k = 0; k < 8; k++) wdat[k] = 64'hBAD0_BAD0_BAD0_BAD0 + 64'(k);
        wr_line(64'h0, 13'h0209, -1, -1);
        for (int k = 0; k < 8; k++) rexp[k] = 64'hD000_0000_0000_0000 | 64'(k);
        rd_line(64'h0, 13'h110A, -1, 0, -1, 1'b0);

        rd_line(64'h0, 13'h110B, -1, 0, 4, 1'b0);
        rd_line(64'h1000, 13'h110C, 6, 1, -1, 1'b0);

        // Write aborted after three beats keeps only those words.
        for (int k = 0; k < 8; k++) wdat[k] = 64'hE0E0_0000_0000_00E0 + 64'(k);
        wr_line(64'h80, 13'h010D, -1, 3);
        for (int k = 0; k < 8; k++)
            rexp[k] = (k < 3) ? 64'hE0E0_0000_0000_00E0 + 64'(k) : 64'h0;
        rd_line(64'h80, 13'h110E, -1, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, backing-store depth in 64-bit words (power of 2).
REQ-002 SHALL have parameter LATENCY, default 4, idle cycles between request acceptance and first read beat (range 1..15).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset (reset==0 resets on next posedge).
REQ-005 SHALL have port reqcyc  in  1  initiator request/write-data valid.
REQ-006 SHALL have port req  in  64  byte address on the request beat; write data on subsequent beats.
REQ-007 SHALL have port reqtag  in  13  {op[12] (1=READ, 0=WRITE), type[11:8] (4'h1=MEMORY), id[7:0]}.
REQ-008 SHALL have port reqack  out  1  one-cycle acceptance pulse per accepted request or write beat.
REQ-009 SHALL have port respcyc  out  1  read data beat valid.
REQ-010 SHALL have port resp  out  64  read data beat.
REQ-011 SHALL have port resptag  out  13  copy of the accepted reqtag, held for the whole burst.
REQ-012 SHALL have port respack  in  1  initiator accepts current beat when high with respcyc.

Function
REQ-013 SHALL implement states IDLE, RD_WAIT, RD_BURST, WR_DATA; one transaction at a time.
REQ-014 IDLE: on reqcyc=1 SHALL latch line base = req & ~63 and reqtag, pulse reqack next cycle; READ -> RD_WAIT, WRITE -> WR_DATA.
REQ-015 SHALL not assert reqack outside IDLE acceptance and WR_DATA beats; reqcyc in RD_WAIT/RD_BURST is ignored (not acked).
REQ-016 RD_WAIT SHALL count LATENCY cycles from the reqack cycle, then enter RD_BURST with respcyc=1.
REQ-017 RD_BURST SHALL emit exactly 8 beats, word 0..7 of the line in increasing address order, word k = bytes base+8k..base+8k+7, little-endian.
REQ-018 resp/resptag SHALL hold stable while respcyc=1 and respack=0; beat index advances only on respcyc&respack.
REQ-019 After beat 7 is acked SHALL drop respcyc next cycle and return to IDLE; a new reqcyc is accepted no earlier than the cycle after return.
REQ-020 WR_DATA SHALL accept 8 data beats, one per cycle with reqcyc=1, each written to word base+8k and acked with reqack one cycle later; reqcyc=0 cycles stall without advancing.
REQ-021 After 8th write beat SHALL return to IDLE; data written SHALL be visible to any later read.
REQ-022 Word index SHALL be (addr>>3) mod MEM_WORDS (wrap-around, no error).
REQ-023 type != 4'h1 (non-MEMORY): read SHALL return 8 beats of 64'h0; write SHALL ack 8 beats and discard data.
REQ-024 respcyc and reqack SHALL never both be 1 in the same cycle.
REQ-025 Backing store SHALL be initialised to zero at time 0 only; reset SHALL NOT clear it.

Reset
REQ-026 On reset==0 at posedge: state=IDLE, reqack=0, respcyc=0, resp=0, resptag=0, beat and latency counters=0.
REQ-027 Reset mid-burst (read or write) SHALL abort the transaction without further beats; partially written words retain written values.
REQ-028 First request SHALL be acceptable in the first cycle reset==1 is sampled.

Verification
REQ-029 Write then read: WRITE tag 13'h0100 at 0x1000, data 0x11..0x88 pattern per beat -> 8 reqack pulses; READ tag 13'h1105 at 0x1000 -> after 4 cycles 8 beats matching data, resptag=13'h1105.
REQ-030 Unaligned read: READ at 0x1013 -> beats start at word 0x1000, not 0x1010.
REQ-031 Backpressure: respack low for 3 cycles on beat 2 -> resp and resptag unchanged, still exactly 8 beats total.
REQ-032 Wrap: write word at 0x0 then read at MEM_WORDS*8 = 0x1000 (MEM_WORDS=512) -> same data returned.
REQ-033 Non-MEMORY read (type 4'h2) -> 8 beats of 64'h0; request arriving during burst -> no reqack until IDLE.
REQ-034 Reset asserted on read beat 4 -> respcyc=0 next cycle, state IDLE, next request served normally.
